// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for LoongArch DIV.W/MOD.W/DIV.WU/MOD.WU.
// It always returns both the quotient and the remainder; the execute stage picks one by op.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   flush          abort any operation in flight and return to idle
//   dividend       dividend operand, sampled only when a start is accepted in idle
//   divisor        divisor operand, sampled only when a start is accepted in idle
//   op             00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU (op[1]=0 selects signed)
//   start          request strobe, accepted only in idle
//   is_running     high while an operation is in progress (calc and fin)
//   quotient_out   registered quotient, updated only on entry to fin
//   remainder_out  registered remainder, updated only on entry to fin
//   done           one-cycle result-valid strobe
module div_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [1:0]            op,
  input  logic                  start,
  output logic                  is_running,
  output logic [DATA_WIDTH-1:0] quotient_out,
  output logic [DATA_WIDTH-1:0] remainder_out,
  output logic                  done
);

  localparam int unsigned Msb = DATA_WIDTH - 1;
  // The counter runs 0..DATA_WIDTH: DATA_WIDTH iterations, then one sign-fixup cycle.
  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   rem_q, rem_d;   // partial remainder, one guard bit
  logic [Msb:0]          quo_q, quo_d;   // holds |dividend| and shifts in quotient bits
  logic [Msb:0]          dvs_q, dvs_d;   // |divisor|
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic [Msb:0]          quot_out_q, quot_out_d;
  logic [Msb:0]          rem_out_q, rem_out_d;

  logic                  signed_op;
  logic [Msb:0]          a_abs, b_abs;
  logic [DATA_WIDTH:0]   rem_shift, rem_sub;

  assign signed_op = ~op[1];
  // Negating 0x8000_0000 yields 0x8000_0000, which is the correct magnitude read as unsigned.
  assign a_abs = (signed_op && dividend[Msb]) ? -dividend : dividend;
  assign b_abs = (signed_op && divisor[Msb])  ? -divisor  : divisor;

  assign rem_shift = {rem_q[Msb:0], quo_q[Msb]};
  assign rem_sub   = rem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          dvs_d   = b_abs;
          rem_d   = '0;
          quo_d   = a_abs;
          cnt_d   = '0;
          q_neg_d = signed_op & (dividend[Msb] ^ divisor[Msb]);
          r_neg_d = signed_op & dividend[Msb];
          state_d = StCalc;
          if (divisor == '0) begin
            // Skip the iterations: preload the fixed result and let the fixup cycle
            // run once. r_neg re-applies the sign, so the remainder is the raw dividend.
            q_neg_d = 1'b0;
            quo_d   = '1;
            rem_d   = {1'b0, a_abs};
            cnt_d   = LastCnt;
          end
        end
      end
      StCalc: begin
        if (cnt_q == LastCnt) begin
          quot_out_d = q_neg_q ? -quo_q : quo_q;
          rem_out_d  = r_neg_q ? -rem_q[Msb:0] : rem_q[Msb:0];
          state_d    = StFin;
        end else begin
          // A clear borrow bit means the shifted remainder is >= the divisor.
          if (!rem_sub[DATA_WIDTH]) begin
            rem_d = rem_sub;
            quo_d = {quo_q[Msb-1:0], 1'b1};
          end else begin
            rem_d = rem_shift;
            quo_d = {quo_q[Msb-1:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (flush) begin
      state_d    = StIdle;
      cnt_d      = '0;
      quot_out_d = quot_out_q;
      rem_out_d  = rem_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
    end
  end

  assign is_running    = (state_q != StIdle);
  assign done          = (state_q == StFin) && !flush;
  assign quotient_out  = quot_out_q;
  assign remainder_out = rem_out_q;

endmodule
